// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit positions, digit patterns and the
// BCD-to-segment decode function used by the lookup sub-module.
package seg7_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_A = 7'b000_0001;
    localparam logic [SEG_W-1:0] SEG_B = 7'b000_0010;
    localparam logic [SEG_W-1:0] SEG_C = 7'b000_0100;
    localparam logic [SEG_W-1:0] SEG_D = 7'b000_1000;
    localparam logic [SEG_W-1:0] SEG_E = 7'b001_0000;
    localparam logic [SEG_W-1:0] SEG_F = 7'b010_0000;
    localparam logic [SEG_W-1:0] SEG_G = 7'b100_0000;

    localparam logic [SEG_W-1:0] DIGIT_0_PAT = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
    localparam logic [SEG_W-1:0] DIGIT_1_PAT = SEG_B | SEG_C;
    localparam logic [SEG_W-1:0] DIGIT_2_PAT = SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
    localparam logic [SEG_W-1:0] DIGIT_3_PAT = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
    localparam logic [SEG_W-1:0] DIGIT_4_PAT = SEG_B | SEG_C | SEG_F | SEG_G;
    localparam logic [SEG_W-1:0] DIGIT_5_PAT = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
    localparam logic [SEG_W-1:0] DIGIT_6_PAT = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
    localparam logic [SEG_W-1:0] DIGIT_7_PAT = SEG_A | SEG_B | SEG_C;
    localparam logic [SEG_W-1:0] DIGIT_8_PAT = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
    localparam logic [SEG_W-1:0] DIGIT_9_PAT = SEG_A | SEG_B | SEG_C | SEG_F | SEG_G;
    localparam logic [SEG_W-1:0] BLANK_PAT   = '0;

    // Active-high pattern; codes 10-15 are not BCD and show blank.
    function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [3:0] digit);
        logic [SEG_W-1:0] pat;
        pat = BLANK_PAT;
        case (digit)
            4'd0:    pat = DIGIT_0_PAT;
            4'd1:    pat = DIGIT_1_PAT;
            4'd2:    pat = DIGIT_2_PAT;
            4'd3:    pat = DIGIT_3_PAT;
            4'd4:    pat = DIGIT_4_PAT;
            4'd5:    pat = DIGIT_5_PAT;
            4'd6:    pat = DIGIT_6_PAT;
            4'd7:    pat = DIGIT_7_PAT;
            4'd8:    pat = DIGIT_8_PAT;
            4'd9:    pat = DIGIT_9_PAT;
            default: pat = BLANK_PAT;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bcd_seg_decoder_if.sv
// Digit-in / segments-out bundle between a digit source and one display digit.
interface bcd_seg_decoder_if;
    logic [3:0] bcd;
    logic [6:0] seven_seg_display;

    modport master (output bcd, input seven_seg_display);
    modport slave  (input bcd, output seven_seg_display);
endinterface

// File: rtl/bcd_seg_decoder_lut.sv
// Combinational 4-to-7 lookup producing the active-high segment pattern.
module bcd_seg_lut
    import seg7_pkg::*;
(
    input  logic [3:0]       bcd,
    output logic [SEG_W-1:0] seg
);

    assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/bcd_seg_decoder.sv
// One-digit BCD to 7-segment decoder with optional polarity inversion and an
// optional asynchronously-reset output register.
module bcd_seg_decoder
    import seg7_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit OUTPUT_REG     = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    bcd_seg_decoder_if.slave   seg_if
);

    // Reset shows a dark display, so it follows the polarity like any pattern.
    localparam logic [SEG_W-1:0] RESET_PAT = SEG_ACTIVE_LOW ? ~BLANK_PAT : BLANK_PAT;

    logic [SEG_W-1:0] seg_raw;
    logic [SEG_W-1:0] seg_next;

    bcd_seg_lut u_lut (
        .bcd (seg_if.bcd),
        .seg (seg_raw)
    );

    genvar gi;
    generate
        for (gi = 0; gi < SEG_W; gi++) begin : g_pol
            assign seg_next[gi] = seg_raw[gi] ^ SEG_ACTIVE_LOW;
        end

        if (OUTPUT_REG) begin : g_reg
            logic [SEG_W-1:0] seg_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    seg_reg <= RESET_PAT;
                end else begin
                    seg_reg <= seg_next;
                end
            end

            assign seg_if.seven_seg_display = seg_reg;
        end else begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;
            assign seg_if.seven_seg_display = seg_next;
        end
    endgenerate

endmodule

// File: tb/tb_bcd_seg_decoder.sv
// Self-checking bench: registered, active-low and combinational decoder
// variants against a segment-letter reference model.
module tb_bcd_seg_decoder;

    logic       clk;
    logic       reset;
    logic [3:0] bcd_drv;

    int total;
    int bad;

    bcd_seg_decoder_if if_def ();
    bcd_seg_decoder_if if_al ();
    bcd_seg_decoder_if if_comb ();

    assign if_def.bcd  = bcd_drv;
    assign if_al.bcd   = bcd_drv;
    assign if_comb.bcd = bcd_drv;

    bcd_seg_decoder #(.SEG_ACTIVE_LOW(1'b0), .OUTPUT_REG(1'b1)) dut (
        .clk    (clk),
        .reset  (reset),
        .seg_if (if_def)
    );

    bcd_seg_decoder #(.SEG_ACTIVE_LOW(1'b1), .OUTPUT_REG(1'b1)) dut_al (
        .clk    (clk),
        .reset  (reset),
        .seg_if (if_al)
    );

    bcd_seg_decoder #(.SEG_ACTIVE_LOW(1'b0), .OUTPUT_REG(1'b0)) dut_comb (
        .clk    (clk),
        .reset  (reset),
        .seg_if (if_comb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: lit segment letters per digit, bit index = letter - 'A'.
    string lit_tab [10] = '{"ABCDEF", "BC", "ABDEG", "ABCDG", "BCFG",
                            "ACDFG", "ACDEFG", "ABC", "ABCDEFG", "ABCFG"};

    function automatic logic [6:0] ref_pat(input int d);
        logic [6:0] m;
        string      s;
        m = 7'h00;
        if (d >= 0 && d <= 9) begin
            s = lit_tab[d];
            for (int i = 0; i < s.len(); i++) begin
                m[int'(s.getc(i)) - 65] = 1'b1;
            end
        end
        return m;
    endfunction

    task automatic drive_bcd(input int v);
        @(negedge clk);
        bcd_drv = v[3:0];
    endtask

    task automatic test_reset();
        logic [6:0] want;
        bcd_drv = 4'd0;
        reset   = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        total++;
        if (if_def.seven_seg_display !== 7'h00) begin
            bad++;
            $display("FAIL reset_async_def: got %h want %h", if_def.seven_seg_display, 7'h00);
        end
        total++;
        if (if_al.seven_seg_display !== 7'h7F) begin
            bad++;
            $display("FAIL reset_async_al: got %h want %h", if_al.seven_seg_display, 7'h7F);
        end
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            total++;
            if (if_def.seven_seg_display !== 7'h00) begin
                bad++;
                $display("FAIL reset_hold_def cyc=%0d: got %h want %h", c, if_def.seven_seg_display, 7'h00);
            end
            total++;
            if (if_al.seven_seg_display !== 7'h7F) begin
                bad++;
                $display("FAIL reset_hold_al cyc=%0d: got %h want %h", c, if_al.seven_seg_display, 7'h7F);
            end
        end
        total++;
        if (if_comb.seven_seg_display !== ref_pat(0)) begin
            bad++;
            $display("FAIL reset_comb: got %h want %h", if_comb.seven_seg_display, ref_pat(0));
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (if_def.seven_seg_display !== 7'h00) begin
            bad++;
            $display("FAIL release_noedge: got %h want %h", if_def.seven_seg_display, 7'h00);
        end
        want = ref_pat(0);
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            total++;
            if (if_def.seven_seg_display !== want) begin
                bad++;
                $display("FAIL release_def cyc=%0d: got %h want %h", c, if_def.seven_seg_display, want);
            end
            total++;
            if (if_al.seven_seg_display !== (~want & 7'h7F)) begin
                bad++;
                $display("FAIL release_al cyc=%0d: got %h want %h", c, if_al.seven_seg_display, ~want & 7'h7F);
            end
        end
    endtask

    task automatic test_all_codes();
        logic [6:0] want;
        logic [6:0] prev;
        prev = ref_pat(int'(bcd_drv));
        for (int v = 0; v < 16; v++) begin
            drive_bcd(v);
            want = ref_pat(v);
            #1;
            total++;
            if (if_comb.seven_seg_display !== want) begin
                bad++;
                $display("FAIL codes_comb bcd=%0d: got %h want %h", v, if_comb.seven_seg_display, want);
            end
            total++;
            if (if_def.seven_seg_display !== prev) begin
                bad++;
                $display("FAIL codes_latency bcd=%0d: got %h want %h", v, if_def.seven_seg_display, prev);
            end
            @(posedge clk);
            #1;
            total++;
            if (if_def.seven_seg_display !== want) begin
                bad++;
                $display("FAIL codes_def bcd=%0d: got %h want %h", v, if_def.seven_seg_display, want);
            end
            total++;
            if (if_al.seven_seg_display !== (~want & 7'h7F)) begin
                bad++;
                $display("FAIL codes_al bcd=%0d: got %h want %h", v, if_al.seven_seg_display, ~want & 7'h7F);
            end
            prev = want;
        end
    endtask

    task automatic test_random();
        int         v;
        logic [6:0] want;
        for (int n = 0; n < 60; n++) begin
            v = int'($urandom_range(0, 15));
            drive_bcd(v);
            want = ref_pat(v);
            #1;
            total++;
            if (if_comb.seven_seg_display !== want) begin
                bad++;
                $display("FAIL random_comb bcd=%0d: got %h want %h", v, if_comb.seven_seg_display, want);
            end
            @(posedge clk);
            #1;
            total++;
            if (if_def.seven_seg_display !== want) begin
                bad++;
                $display("FAIL random_def bcd=%0d: got %h want %h", v, if_def.seven_seg_display, want);
            end
            total++;
            if (if_al.seven_seg_display !== (~want & 7'h7F)) begin
                bad++;
                $display("FAIL random_al bcd=%0d: got %h want %h", v, if_al.seven_seg_display, ~want & 7'h7F);
            end
        end
    endtask

    task automatic test_async_reset();
        drive_bcd(8);
        @(posedge clk);
        #1;
        total++;
        if (if_def.seven_seg_display !== 7'h7F) begin
            bad++;
            $display("FAIL midreset_pre: got %h want %h", if_def.seven_seg_display, 7'h7F);
        end
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (if_def.seven_seg_display !== 7'h00) begin
            bad++;
            $display("FAIL midreset_def: got %h want %h", if_def.seven_seg_display, 7'h00);
        end
        total++;
        if (if_al.seven_seg_display !== 7'h7F) begin
            bad++;
            $display("FAIL midreset_al: got %h want %h", if_al.seven_seg_display, 7'h7F);
        end
        bcd_drv = 4'd3;
        @(posedge clk);
        #1;
        total++;
        if (if_def.seven_seg_display !== 7'h00) begin
            bad++;
            $display("FAIL midreset_hold: got %h want %h", if_def.seven_seg_display, 7'h00);
        end
        @(negedge clk);
        bcd_drv = 4'd8;
        reset   = 1'b1;
        #1;
        total++;
        if (if_def.seven_seg_display !== 7'h00) begin
            bad++;
            $display("FAIL midreset_release_noedge: got %h want %h", if_def.seven_seg_display, 7'h00);
        end
        @(posedge clk);
        #1;
        total++;
        if (if_def.seven_seg_display !== ref_pat(8)) begin
            bad++;
            $display("FAIL midreset_release_def: got %h want %h", if_def.seven_seg_display, ref_pat(8));
        end
        total++;
        if (if_al.seven_seg_display !== (~ref_pat(8) & 7'h7F)) begin
            bad++;
            $display("FAIL midreset_release_al: got %h want %h", if_al.seven_seg_display, ~ref_pat(8) & 7'h7F);
        end
    endtask

    task automatic test_mid_cycle();
        drive_bcd(1);
        @(posedge clk);
        #1;
        total++;
        if (if_def.seven_seg_display !== ref_pat(1)) begin
            bad++;
            $display("FAIL midcycle_pre: got %h want %h", if_def.seven_seg_display, ref_pat(1));
        end
        total++;
        if (if_al.seven_seg_display !== (~ref_pat(1) & 7'h7F)) begin
            bad++;
            $display("FAIL midcycle_al_one: got %h want %h", if_al.seven_seg_display, ~ref_pat(1) & 7'h7F);
        end
        #2;
        bcd_drv = 4'd7;
        #2;
        total++;
        if (if_def.seven_seg_display !== ref_pat(1)) begin
            bad++;
            $display("FAIL midcycle_hold: got %h want %h", if_def.seven_seg_display, ref_pat(1));
        end
        @(posedge clk);
        #1;
        total++;
        if (if_def.seven_seg_display !== ref_pat(7)) begin
            bad++;
            $display("FAIL midcycle_post: got %h want %h", if_def.seven_seg_display, ref_pat(7));
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        bcd_drv = 4'd0;
        test_reset();
        test_all_codes();
        test_random();
        test_async_reset();
        test_mid_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
